// File: rtl/result_requant.sv
// Requantizes N-lane matmul result rows: per-column bias, rounding right shift,
// optional ReLU and saturation to OUT_WIDTH, with tile-based tlast on AXI-Stream.
module result_requant #(
  parameter int N             = 4,
  parameter int RESULT_WIDTH  = 32,
  parameter int OUT_WIDTH     = 8,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N*RESULT_WIDTH-1:0]       s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [N*OUT_WIDTH-1:0]          m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            bias_wr_en,
  input  logic [$clog2(N)-1:0]            bias_wr_idx,
  input  logic signed [RESULT_WIDTH-1:0]  bias_wr_data,
  input  logic [4:0]                      cfg_shift,
  input  logic                            cfg_relu,
  input  logic [ROW_CNT_WIDTH-1:0]        cfg_rows
);

  localparam int SW  = RESULT_WIDTH + 1;
  localparam int RW2 = RESULT_WIDTH + 2;
  localparam logic signed [RW2-1:0] SAT_MAX =
    {{(RW2-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW2-1:0] SAT_MIN =
    {{(RW2-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic signed [RW2-1:0] round_shift(
    input logic signed [SW-1:0] sum,
    input logic [4:0]           sh
  );
    logic signed [RW2-1:0] ext;
    logic signed [RW2-1:0] rnd;
    ext = {sum[SW-1], sum};
    rnd = '0;
    if (sh != 5'd0) rnd = {{(RW2-1){1'b0}}, 1'b1} << (sh - 5'd1);
    return (ext + rnd) >>> sh;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_relu(
    input logic signed [RW2-1:0] r,
    input logic                  relu
  );
    logic signed [RW2-1:0] c;
    if (r > SAT_MAX)      c = SAT_MAX;
    else if (r < SAT_MIN) c = SAT_MIN;
    else                  c = r;
    if (relu && c[RW2-1]) c = '0;
    return c[OUT_WIDTH-1:0];
  endfunction

  logic signed [RESULT_WIDTH-1:0] bias_q [N];
  logic                           vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic signed [SW-1:0]           sum_p1_q [N];
  logic signed [SW-1:0]           sum_p1_d [N];
  logic                           vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic [N*OUT_WIDTH-1:0]         data_p2_q, data_p2_d;
  logic [ROW_CNT_WIDTH-1:0]       row_q, row_d, rows_m1;
  logic                           accept, p2_free, p2_load, row_last;

  always_comb begin
    p2_free       = !vld_p2_q || m_axis_tready;
    p2_load       = vld_p1_q && p2_free;
    s_axis_tready = !vld_p1_q || p2_free;
    accept        = s_axis_tvalid && s_axis_tready;

    // Stage 1: bias add and row tagging on accept
    rows_m1   = (cfg_rows == '0) ? '0 : cfg_rows - 1'b1;
    row_last  = (row_q >= rows_m1);
    row_d     = row_q;
    last_p1_d = last_p1_q;
    if (accept) begin
      last_p1_d = row_last;
      row_d     = row_last ? '0 : row_q + 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      sum_p1_d[i] = sum_p1_q[i];
      if (accept)
        sum_p1_d[i] =
          $signed({s_axis_tdata[i*RESULT_WIDTH+RESULT_WIDTH-1],
                   s_axis_tdata[i*RESULT_WIDTH +: RESULT_WIDTH]}) +
          $signed({bias_q[i][RESULT_WIDTH-1], bias_q[i]});
    end
    vld_p1_d = accept ? 1'b1 : (p2_load ? 1'b0 : vld_p1_q);

    // Stage 2: round, saturate, ReLU into the output register
    data_p2_d = data_p2_q;
    last_p2_d = last_p2_q;
    if (p2_load) begin
      last_p2_d = last_p1_q;
      for (int i = 0; i < N; i++)
        data_p2_d[i*OUT_WIDTH +: OUT_WIDTH] =
          sat_relu(round_shift(sum_p1_q[i], cfg_shift), cfg_relu);
    end
    vld_p2_d = p2_load ? 1'b1 : (m_axis_tready ? 1'b0 : vld_p2_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      data_p2_q <= '0;
      row_q     <= '0;
      for (int i = 0; i < N; i++) bias_q[i] <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
      data_p2_q <= data_p2_d;
      row_q     <= row_d;
      if (bias_wr_en) bias_q[bias_wr_idx] <= bias_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) sum_p1_q[i] <= sum_p1_d[i];
  end

  assign m_axis_tvalid = vld_p2_q;
  assign m_axis_tdata  = data_p2_q;
  assign m_axis_tlast  = last_p2_q;

endmodule
